// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared loader states, word geometry and default reset vector
package prog_loader_pkg;
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR} loader_state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFC00000;
endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input and memory write port of the program loader
interface prog_loader_if #(parameter int ADDRESS_WIDTH = 32);
  logic                     in_valid;
  logic [7:0]               in_data;
  logic                     in_ready;
  logic                     mem_we;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [ADDRESS_WIDTH-1:0] mem_wdata;
  logic                     mem_ready;
  modport master (input in_valid, in_data, mem_ready, output in_ready, mem_we, mem_addr, mem_wdata);
  modport slave (output in_valid, in_data, mem_ready, input in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: little-endian 4-byte word assembler with wrapping byte counter
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic [31:0] word_next,
  output logic        word_complete
);
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  always_comb begin
    word_d = word_q;
    if (en) word_d[8*cnt_q +: 8] = in_byte;
    cnt_d = clr ? 2'd0 : en ? cnt_q + 2'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end
  assign word          = word_q;
  assign word_next     = word_d;
  assign word_complete = en & (cnt_q == 2'd3);
endmodule

// File: rtl/prog_loader.sv
// prog_loader: length-prefixed byte-stream loader into instruction memory; PROG_LOADER_CHECKSUM_EN adds a trailing sum check
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int                     ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR   = ADDRESS_WIDTH'(DEFAULT_BASE_ADDR),
  parameter int                     MEM_BYTES     = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  prog_loader_if.master bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);
  localparam logic [31:0] MAX_WORDS = 32'(MEM_BYTES / BYTES_PER_WORD);
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam loader_state_t FIN = CSUM;
  logic [31:0] sum_q, sum_d;
`else
  localparam loader_state_t FIN = DONE;
`endif
  loader_state_t state_q, state_d;
  logic [31:0] len_q, len_d, idx_q, idx_d, word, word_next;
  logic idle, clr, byte_fire, wr_fire, word_complete;
  assign idle      = state_q inside {IDLE, DONE, ERR};
  assign clr       = idle & start;
  assign byte_fire = bus.in_valid & bus.in_ready;
  assign wr_fire   = bus.mem_we & bus.mem_ready;
  assign bus.in_ready  = state_q inside {LEN, DATA, CSUM};
  assign bus.mem_we    = state_q == WRITE;
  assign bus.mem_addr  = BASE_ADDR + ADDRESS_WIDTH'({idx_q[29:0], 2'b00});
  assign bus.mem_wdata = ADDRESS_WIDTH'(word);
  assign cpu_hold = !idle;
  assign done     = state_q == DONE;
  assign err      = state_q == ERR;
  byte_packer u_packer (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(byte_fire), .in_byte(bus.in_data),
    .word(word), .word_next(word_next), .word_complete(word_complete)
  );
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    if (clr) sum_d = '0;
    if (wr_fire) sum_d = sum_q + word;
    if (state_q == CSUM && word_complete) state_d = word_next == sum_q ? DONE : ERR;
`endif
    if (clr) begin
      state_d = LEN;
      idx_d   = '0;
    end
    if (state_q == LEN && word_complete) begin
      len_d   = word_next;
      state_d = word_next == '0 ? FIN : word_next > MAX_WORDS ? ERR : DATA;
    end
    if (state_q == DATA && word_complete) state_d = WRITE;
    if (wr_fire) begin
      idx_d   = idx_q + 32'd1;
      state_d = idx_q + 32'd1 == len_q ? FIN : DATA;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed vectors for the byte-stream program loader
module tb_prog_loader;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic cpu_hold, done, err;
  int vectors = 0, miscompares = 0, stall_n = 0, we_cnt = 0;
  logic stalling = 1'b0;
  logic [31:0] s_addr, s_data;
  logic [31:0] wa[$], wd[$];
  prog_loader_if bus();
  prog_loader dut (.clk(clk), .rst_n(rst_n), .start(start), .bus(bus), .cpu_hold(cpu_hold), .done(done), .err(err));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.mem_we && stall_n > 0) begin
      if (!stalling) begin
        s_addr   = bus.mem_addr;
        s_data   = bus.mem_wdata;
        stalling = 1'b1;
      end else begin
        check("stall_addr", bus.mem_addr, s_addr);
        check("stall_data", bus.mem_wdata, s_data);
      end
      check("in_ready_in_write", 32'(bus.in_ready), 32'd0);
      bus.mem_ready = 1'b0;
      stall_n--;
    end else begin
      if (stalling && bus.mem_we) begin
        check("stall_end_addr", bus.mem_addr, s_addr);
        check("stall_end_data", bus.mem_wdata, s_data);
      end
      stalling      = 1'b0;
      bus.mem_ready = 1'b1;
    end
    if (bus.mem_we) we_cnt++;
    if (bus.mem_we && bus.mem_ready) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end
  end
  task automatic clear_log;
    wa.delete();
    wd.delete();
    we_cnt = 0;
  endtask
  task automatic pulse_start;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask
  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask
  task automatic wait_end;
    int n = 0;
    while (!(done || err) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(done || err)) check("end_timeout", 32'(done | err), 32'd1);
  endtask
  task automatic run_basic(input string tag, input int gap, input logic [31:0] csum);
    clear_log();
    pulse_start();
    check({tag, "_hold_busy"}, 32'(cpu_hold), 32'd1);
    send_word(32'd2, gap);
    send_word(32'h00A00513, gap);
    send_word(32'h00B00593, gap);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(csum, gap);
`else
    if (csum != 32'h01500AA6) check({tag, "_csum_arg"}, csum, 32'h01500AA6);
`endif
    wait_end();
    check({tag, "_n_writes"}, 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      check({tag, "_addr0"}, wa[0], 32'hBFC00000);
      check({tag, "_data0"}, wd[0], 32'h00A00513);
      check({tag, "_addr1"}, wa[1], 32'hBFC00004);
      check({tag, "_data1"}, wd[1], 32'h00B00593);
    end
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'hBFC00000);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_basic("basic", 0, 32'h01500AA6);
    check("basic_done", 32'(done), 32'd1);
    check("basic_err", 32'(err), 32'd0);
    clear_log();
    pulse_start();
    send_word(32'd0, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(32'd0, 0);
`endif
    check("zero_done", 32'(done), 32'd1);
    check("zero_err", 32'(err), 32'd0);
    check("zero_no_we", 32'(we_cnt), 32'd0);
    clear_log();
    pulse_start();
    send_word(32'h00000401, 0);
    wait_end();
    check("over_err", 32'(err), 32'd1);
    check("over_done", 32'(done), 32'd0);
    check("over_in_ready", 32'(bus.in_ready), 32'd0);
    check("over_no_we", 32'(we_cnt), 32'd0);
    check("over_cpu_hold", 32'(cpu_hold), 32'd0);
    stall_n = 3;
    run_basic("bp", 1, 32'h01500AA6);
    check("bp_stall_used", 32'(stall_n), 32'd0);
    check("bp_done", 32'(done), 32'd1);
    check("bp_err", 32'(err), 32'd0);
    clear_log();
    pulse_start();
    send_word(32'd2, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_in_ready", 32'(bus.in_ready), 32'd0);
    check("mid_mem_we", 32'(bus.mem_we), 32'd0);
    check("mid_mem_addr", bus.mem_addr, 32'hBFC00000);
    check("mid_mem_wdata", bus.mem_wdata, 32'd0);
    check("mid_cpu_hold", 32'(cpu_hold), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_err", 32'(err), 32'd0);
    check("mid_no_we", 32'(we_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    send_word(32'd1, 0);
    send_word(32'hDEADBEEF, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(32'hDEADBEEF, 0);
`endif
    wait_end();
    check("mid_n_writes", 32'(wa.size()), 32'd1);
    if (wa.size() == 1) begin
      check("mid_addr0", wa[0], 32'hBFC00000);
      check("mid_data0", wd[0], 32'hDEADBEEF);
    end
    check("mid_reload_done", 32'(done), 32'd1);
`ifdef PROG_LOADER_CHECKSUM_EN
    run_basic("csum_bad", 0, 32'h01500AA7);
    check("csum_bad_err", 32'(err), 32'd1);
    check("csum_bad_done", 32'(done), 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader: the write side of the instruction memory.
- Receives a length-prefixed little-endian byte stream, for example from a UART receiver.
- Assembles each group of 4 bytes into a 32-bit word and writes the words into instruction memory, starting at the reset vector.
- Holds the CPU in reset while loading; reports done or error.

Parameters:
- ADDRESS_WIDTH, 32: width of the memory address and data.
- BASE_ADDR, 32'hBFC00000: byte address of the first word written.
- MEM_BYTES, 4096: instruction memory capacity in bytes. Maximum load is MEM_BYTES/4 words.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  loader accepts the byte this cycle.
- mem_we  out  1  word write request.
- mem_addr  out  ADDRESS_WIDTH  word-aligned byte address.
- mem_wdata  out  ADDRESS_WIDTH  word; first byte received in [7:0].
- mem_ready  in  1  memory accepts the write this cycle.
- cpu_hold  out  1  high while busy; drives the core reset.
- done  out  1  level; load completed successfully.
- err  out  1  level; load aborted.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state goes to IDLE; all counters clear.
  - in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=0, done=0, err=0.
  - Reset mid-load abandons the load immediately; no further mem_we is issued.
- Byte transfer: occurs on a cycle where in_valid and in_ready are both high.
- Write transfer: occurs on a cycle where mem_we and mem_ready are both high.
- States:
  - IDLE/DONE/ERR: in_ready=0. start moves to LEN, clears done, err, the byte counter and the word counter, and sets cpu_hold=1. start is ignored in other states.
  - LEN: in_ready=1. Collects 4 bytes into len_words (little-endian).
    - On the 4th byte, len_words==0 goes to DONE (or CSUM when the feature is enabled).
    - len_words > MEM_BYTES/4 goes to ERR.
    - Otherwise goes to DATA.
  - DATA: in_ready=1. Shifts bytes into a word register; byte k of the word goes to bits [8k+7:8k]. On the 4th byte, goes to WRITE.
  - WRITE: in_ready=0, mem_we=1.
    - mem_addr = BASE_ADDR + 4*word_idx; mem_wdata is the assembled word.
    - mem_addr and mem_wdata are held stable until mem_ready.
    - On write transfer: word_idx increments. If word_idx+1 == len_words, go to DONE (or CSUM). Otherwise go to DATA.
  - DONE: done=1, cpu_hold=0.
  - ERR: err=1, cpu_hold=0.
- Timing:
  - mem_we rises the cycle after the 4th byte transfer.
  - Minimum 5 cycles per word when input and memory never stall.
- Arithmetic:
  - Byte counter: 2 bits, wraps 3→0.
  - word_idx: 32 bits internally; compared against len_words.
  - Address addition: modulo 2^ADDRESS_WIDTH.
- in_valid while in_ready=0 is not consumed. The source must hold the byte.
- done and err are never both high.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - After the last word (or after LEN when length is 0), state CSUM collects 4 more bytes (little-endian).
  - These are compared with the 32-bit modulo-2^32 sum of all written words.
  - Match goes to DONE; mismatch goes to ERR.
  - The running sum clears on start.
- Undefined: no CSUM state and no sum register; the final word goes straight to DONE.

Decomposition:
- Package prog_loader_pkg holds:
  - state enum loader_state_t {IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR};
  - localparam BYTES_PER_WORD=4;
  - the default BASE_ADDR constant, shared with the instruction memory range definition.
- One sub-module, byte_packer:
  - 4-byte little-endian shift/assemble register with byte counter;
  - outputs word and word_complete;
  - reused for the length, data and checksum fields.

Test Plan:
- Basic load:
  - Stimulus: start; bytes 02 00 00 00, 13 05 A0 00, 93 05 B0 00, no stalls.
  - Required: writes 0x00A00513 @0xBFC00000, then 0x00B00593 @0xBFC00004. done=1, cpu_hold falls, err=0.
- Zero length:
  - Stimulus: start; bytes 00 00 00 00.
  - Required: no mem_we; done=1 the cycle after the 4th byte.
- Oversize:
  - Stimulus: length 0x00000401 with MEM_BYTES=4096.
  - Required: err=1, no mem_we, in_ready=0.
- Backpressure:
  - Stimulus: mem_ready held low 3 cycles during the first write; in_valid toggles every other cycle.
  - Required: mem_addr and mem_wdata stable while stalled; in_ready=0 during WRITE; no byte lost or duplicated; same result as the basic load.
- Reset mid-load:
  - Stimulus: rst_n low after 2 data bytes of word 1, then start plus a full 1-word stream.
  - Required: outputs at reset values; the new load writes its word @0xBFC00000.
- Checksum (PROG_LOADER_CHECKSUM_EN):
  - Stimulus: the basic stream plus checksum bytes A6 0A 50 01 (0x01500AA6). Repeat with A7 0A 50 01.
  - Required: done=1 for the first; err=1 for the second.
